// File: rtl/dmem_access_unit.sv
// Data-memory initiator for the MEM stage: one load/store at a time, lane formatting,
// and splitting of word-crossing misaligned accesses into two word transactions.
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addrD,
  output logic              mem_renD,
  input  logic [31:0]       mem_rdataD,
  output logic              mem_wenD,
  output logic [31:0]       mem_wdataD,
  output logic [3:0]        mem_MaskD
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_DONE, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_buf_q;

  logic              accept, req_legal, split;
  logic [1:0]        off;
  logic [2:0]        size;
  logic [3:0]        lanes;
  logic [31:0]       wdata_sized, lo_word, shifted, load_fmt;
  logic [7:0]        mask8;
  logic [63:0]       wide_w;
  logic [ADDR_W-1:0] word0, word1;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'd0, 3'd1, 3'd2: req_legal = 1'b1;
      3'd4, 3'd5:       req_legal = !req_we;
      default:          req_legal = 1'b0;
    endcase
  end

  // Width decode of the captured request; illegal codes never reach the issue states.
  always_comb begin
    size        = 3'd4;
    lanes       = 4'b1111;
    wdata_sized = wdata_q;
    case (funct3_q[1:0])
      2'd0: begin size = 3'd1; lanes = 4'b0001; wdata_sized = {24'b0, wdata_q[7:0]};  end
      2'd1: begin size = 3'd2; lanes = 4'b0011; wdata_sized = {16'b0, wdata_q[15:0]}; end
      default: ;
    endcase
  end

  assign off    = addr_q[1:0];
  assign split  = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign mask8  = {4'b0000, lanes} << off;
  assign wide_w = {32'b0, wdata_sized} << {off, 3'b000};
  assign word0  = {addr_q[ADDR_W-1:2], 2'b00};
  assign word1  = word0 + ADDR_W'(4);

  assign lo_word = split ? lo_buf_q : mem_rdataD;
  assign shifted = 32'({mem_rdataD, lo_word} >> {off, 3'b000});

  always_comb begin
    case (funct3_q)
      3'd0:    load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_fmt = {24'b0, shifted[7:0]};
      3'd5:    load_fmt = {16'b0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the request registers are reset too, so outputs are clean straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_buf_q <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == S_ISSUE1 && !we_q) lo_buf_q <= mem_rdataD;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = req_legal ? S_ISSUE0 : S_FAULT;
      S_ISSUE0: state_d = split ? S_ISSUE1 : (we_q ? S_IDLE : S_DONE);
      S_ISSUE1: state_d = we_q ? S_IDLE : S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = 1'b0;
    mem_addrD  = '0;
    mem_renD   = 1'b0;
    mem_wenD   = 1'b0;
    mem_wdataD = '0;
    mem_MaskD  = '0;
    case (state_q)
      S_ISSUE0: begin
        mem_addrD = word0;
        if (we_q) begin
          mem_wenD   = 1'b1;
          mem_MaskD  = mask8[3:0];
          mem_wdataD = wide_w[31:0];
          resp_valid = !split;
        end else begin
          mem_renD = 1'b1;
        end
      end
      S_ISSUE1: begin
        mem_addrD = word1;
        if (we_q) begin
          mem_wenD   = 1'b1;
          mem_MaskD  = mask8[7:4];
          mem_wdataD = wide_w[63:32];
          resp_valid = 1'b1;
        end else begin
          mem_renD = 1'b1;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = load_fmt;
      end
      S_FAULT: begin
        resp_valid = 1'b1;
        resp_fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a small one-cycle-latency memory model.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addrD, mem_rdataD, mem_wdataD;
  logic        mem_renD, mem_wenD;
  logic [3:0]  mem_MaskD;

  int checks   = 0;
  int failures = 0;

  dmem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addrD(mem_addrD), .mem_renD(mem_renD), .mem_rdataD(mem_rdataD),
    .mem_wenD(mem_wenD), .mem_wdataD(mem_wdataD), .mem_MaskD(mem_MaskD)
  );

  always #5 clk = ~clk;

  // Memory model: word index from address bits [9:2]; 0x100/0x104/0x0/0xFFFFFFFC stay distinct.
  logic [31:0] mem [256];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h8899AABB;
      mem[8'h41] <= 32'h11223344;
    end else begin
      if (mem_renD) mem_rdataD <= mem[mem_addrD[9:2]];
      if (mem_wenD)
        for (int b = 0; b < 4; b++)
          if (mem_MaskD[b]) mem[mem_addrD[9:2]][8*b +: 8] <= mem_wdataD[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reload_mem();
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
  endtask

  // Per-cycle log of one transaction; index n = cycles after the accept edge.
  logic        log_ren  [7];
  logic        log_wen  [7];
  logic [31:0] log_addr [7];
  logic [31:0] log_wd   [7];
  logic [3:0]  log_mask [7];
  int          lat, nstrobes, both;
  logic [31:0] got_rdata;
  logic        got_fault;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    for (int i = 0; i < 7; i++) begin
      log_ren[i] = 0; log_wen[i] = 0; log_addr[i] = 0; log_wd[i] = 0; log_mask[i] = 0;
    end
    lat = 0; nstrobes = 0; both = 0; got_rdata = 32'hx; got_fault = 1'bx;
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    tick();
    // Garbage on the request bus after acceptance must be ignored.
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'd7; req_addr = 32'h0; req_wdata = '1;
    for (int n = 1; n <= 6; n++) begin
      log_ren[n] = mem_renD; log_wen[n] = mem_wenD; log_addr[n] = mem_addrD;
      log_wd[n] = mem_wdataD; log_mask[n] = mem_MaskD;
      if (mem_renD && mem_wenD) both++;
      if (mem_renD || mem_wenD) nstrobes++;
      if (resp_valid) begin
        lat = n; got_rdata = resp_rdata; got_fault = resp_fault;
        break;
      end
      tick();
    end
    check("strobe_exclusive", both, 0);
    tick();
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'h0);
    check({tag, "_rdata"}, got_rdata, exp);
    check({tag, "_lat"}, lat, 2);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_init = 1'b1;
    tick(); tick();
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_strobes", {mem_renD, mem_wenD}, 0);
    check("rst_addr_mask_wd", {mem_addrD, mem_MaskD, mem_wdataD}, 0);
    check("rst_rdata_fault", {resp_rdata, resp_fault}, 0);
    rst_n = 1'b1; mem_init = 1'b0;
    tick();

    // Aligned word load
    do_req(1'b0, 3'd2, 32'h100, 32'h0);
    check("lw_lat", lat, 2);
    check("lw_rdata", got_rdata, 32'h8899AABB);
    check("lw_fault", got_fault, 0);
    check("lw_c1", {log_ren[1], log_addr[1]}, {1'b1, 32'h100});
    check("lw_nreads", nstrobes, 1);

    load_check("lb_103", 3'd0, 32'h103, 32'hFFFFFF88);
    load_check("lbu_103", 3'd4, 32'h103, 32'h00000088);
    load_check("lhu_102", 3'd5, 32'h102, 32'h00008899);
    load_check("lh_102", 3'd1, 32'h102, 32'hFFFF8899);

    // Split halfword load
    do_req(1'b0, 3'd1, 32'h103, 32'h0);
    check("lh_split_lat", lat, 3);
    check("lh_split_rdata", got_rdata, 32'h00004488);
    check("lh_split_c1", {log_ren[1], log_addr[1]}, {1'b1, 32'h100});
    check("lh_split_c2", {log_ren[2], log_addr[2]}, {1'b1, 32'h104});

    // Split word store and readback
    do_req(1'b1, 3'd2, 32'h102, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_c1", {log_wen[1], log_addr[1], log_mask[1], log_wd[1]},
          {1'b1, 32'h100, 4'b1100, 32'hBEEF0000});
    check("sw_c2", {log_wen[2], log_addr[2], log_mask[2], log_wd[2]},
          {1'b1, 32'h104, 4'b0011, 32'h0000DEAD});
    check("sw_rdata_zero", got_rdata, 0);
    load_check("sw_rb_100", 3'd2, 32'h100, 32'hBEEFAABB);
    load_check("sw_rb_104", 3'd2, 32'h104, 32'h1122DEAD);

    reload_mem();
    // Aligned byte store: upper wdata bits must not leak into other lanes
    do_req(1'b1, 3'd0, 32'h101, 32'hFFFFFF5A);
    check("sb_lat", lat, 1);
    check("sb_c1", {log_wen[1], log_addr[1], log_mask[1], log_wd[1]},
          {1'b1, 32'h100, 4'b0010, 32'h00005A00});
    load_check("sb_rb", 3'd2, 32'h100, 32'h88995ABB);

    // Illegal codes
    do_req(1'b0, 3'd3, 32'h100, 32'h0);
    check("fault_ld", {lat, 31'b0, got_fault, got_rdata}, {32'd1, 31'b0, 1'b1, 32'h0});
    check("fault_ld_nostrobe", nstrobes, 0);
    do_req(1'b1, 3'd4, 32'h100, 32'h12345678);
    check("fault_st", {lat, 31'b0, got_fault, got_rdata}, {32'd1, 31'b0, 1'b1, 32'h0});
    check("fault_st_nostrobe", nstrobes, 0);

    // Address wrap on the second half
    do_req(1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000A5C3);
    check("sh_wrap_lat", lat, 2);
    check("sh_wrap_c1", {log_wen[1], log_addr[1], log_mask[1], log_wd[1]},
          {1'b1, 32'hFFFFFFFC, 4'b1000, 32'hC3000000});
    check("sh_wrap_c2", {log_wen[2], log_addr[2], log_mask[2], log_wd[2]},
          {1'b1, 32'h00000000, 4'b0001, 32'h000000A5});

    // Reset during the ISSUE1 cycle of a split load
    reload_mem();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd1; req_addr = 32'h103;
    tick();
    req_valid = 1'b0;
    check("rstmid_issue0_ren", mem_renD, 1);
    tick();
    check("rstmid_issue1_addr", {mem_renD, mem_addrD}, {1'b1, 32'h104});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_after", {resp_valid, mem_renD, mem_wenD, req_ready}, 4'b0001);
    tick();
    check("rstmid_after2", {resp_valid, mem_renD, mem_wenD, req_ready}, 4'b0001);
    load_check("rstmid_lw_104", 3'd2, 32'h104, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the synchronous data-memory port: sits in the core's MEM stage, accepts one load/store request at a time from the pipeline, and drives addrD/renD/wenD/wdataD/MaskD of the shared memory.
- Formats byte/half/word load data (sign/zero extension) and lane-shifts store data and masks.
- Splits misaligned accesses that cross a word boundary into two word transactions.
- Memory read latency is one clock: data is valid the cycle after renD.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addrD.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  32  formatted load data; 0 for stores and faults
- resp_fault  out  1  illegal width code, qualified by resp_valid
- mem_addrD  out  ADDR_W  word-aligned address to memory (bits [1:0] = 0)
- mem_renD  out  1  memory read enable
- mem_rdataD  in  32  memory read data, valid the cycle after mem_renD
- mem_wenD  out  1  memory write enable
- mem_wdataD  out  32  lane-positioned write data
- mem_MaskD  out  4  byte-lane write mask, bit i = bits [8i+7:8i]

Behaviour:
- Clock and reset: clk is the only clock. rst_n is synchronous and active-low.
- Request capture: a request is accepted when req_valid && req_ready. On acceptance, we, funct3, addr and wdata are registered; later changes on req_* are ignored.
- Decode of the captured request:
  - size = 1/2/4 bytes from funct3.
  - off = addr[1:0].
  - split = (off + size > 4).
  - Legal codes: loads 0,1,2,4,5; stores 0,1,2. Any other code is illegal.
- States:
  - IDLE: req_ready = 1. On accept, go to FAULT if the code is illegal, otherwise to ISSUE0.
  - ISSUE0: mem_addrD = {addr[31:2],2'b00}.
    - Load: mem_renD = 1. Next state is ISSUE1 if split, else DONE.
    - Store: mem_wenD = 1, mem_MaskD = lo mask, mem_wdataD = lo data. If not split, resp_valid = 1 and go to IDLE; otherwise go to ISSUE1.
  - ISSUE1: mem_addrD = word0 + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
    - Load: capture mem_rdataD into lo_buf, mem_renD = 1, go to DONE.
    - Store: mem_wenD = 1 with hi mask/data, resp_valid = 1, go to IDLE.
  - DONE (loads only): resp_valid = 1, resp_rdata = formatted data, go to IDLE.
  - FAULT: resp_valid = 1, resp_fault = 1, resp_rdata = 0, go to IDLE. No memory strobes are issued.
- Store lane math:
  - 64-bit data = zero-extended wdata << 8*off; lo data = bits [31:0], hi data = bits [63:32].
  - 8-bit mask = ((1<<size)-1) << off; lo mask = [3:0], hi mask = [7:4].
  - Unused lanes of mem_wdataD are 0.
- Load formatting:
  - 64-bit word = {hi, lo}, where lo = lo_buf if split, else mem_rdataD; hi = mem_rdataD.
  - Shift the word right by 8*off and take size bytes.
  - funct3 0/1: sign-extend. 4/5: zero-extend. 2: no extension.
- Latency from the accept cycle:
  - aligned store: resp in cycle +1
  - split store: +2
  - aligned load: +2
  - split load: +3
  - fault: +1
- Strobe exclusivity: mem_renD and mem_wenD are never both 1. Both are 0 in IDLE, DONE and FAULT. When a strobe is 0, mem_addrD, mem_wdataD and mem_MaskD hold 0.
- Back-to-back: req_ready = 1 again in the cycle after resp_valid. There is no request pipelining.
- Reset:
  - While rst_n = 0 at a clock edge: state becomes IDLE and lo_buf is cleared.
  - All outputs are 0 in the cycle after reset, except req_ready = 1.
  - Reset mid-transaction abandons it: no resp_valid, no further strobes. A first-half store write already issued is not undone.

Test Plan:
Initial memory for every scenario: word 0x100 = 0x8899AABB, word 0x104 = 0x11223344.
- LW 0x100 -> one renD at 0x100. resp_valid 2 cycles after accept, rdata = 0x8899AABB, fault = 0.
- LB 0x103 -> rdata = 0xFFFFFF88. LBU 0x103 -> 0x00000088. LHU 0x102 -> 0x00008899.
- LH 0x103 (split) -> renD at 0x100 then 0x104 on consecutive cycles. resp 3 cycles after accept, rdata = 0x00004488.
- SW 0x102 data 0xDEADBEEF:
  - cycle +1: addrD = 0x100, mask = 4'b1100, wdataD = 0xBEEF0000.
  - cycle +2: addrD = 0x104, mask = 4'b0011, wdataD = 0x0000DEAD; resp_valid in this cycle.
  - Readback: 0x100 = 0xBEEFAABB, 0x104 = 0x1122DEAD.
- Fault and wrap:
  - Load funct3 = 3 at 0x100 -> resp_valid + resp_fault at +1, rdata = 0, no strobes.
  - Store funct3 = 4 -> same response.
  - SH 0xFFFFFFFF -> second write goes to addrD = 0x00000000 with mask 4'b0001.
- Reset during split LH (rst_n low in the ISSUE1 cycle) -> no resp_valid, strobes 0 next cycle, req_ready = 1. A following LW 0x104 returns 0x11223344.
